// File: rtl/ts_packet_source.sv
// Multi-channel MPEG-2 transport-stream packet generator with deterministic payload,
// valid/ready flow control, optional inter-packet gaps and continuity-counter loss injection.
module ts_packet_source #(
    parameter int          NUM_CH     = 4,
    parameter int          PKT_LEN    = 188,
    parameter logic [12:0] PID_BASE   = 13'h0100,
    parameter int          GAP_CYCLES = 0,
    parameter int          DROP_EVERY = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      enable,
    input  logic [NUM_CH-1:0]      ready,
    output logic [NUM_CH-1:0]      valid,
    output logic [NUM_CH*8-1:0]    byte_data,
    output logic [NUM_CH-1:0]      sop,
    output logic [NUM_CH-1:0]      eop,
    output logic [NUM_CH-1:0]      loss_pulse,
    output logic [NUM_CH*16-1:0]   pkt_cnt
);

    // Index is at least 8 bits wide so the payload formula can always take idx[7:0].
    localparam int                IDX_W    = ($clog2(PKT_LEN) > 8) ? $clog2(PKT_LEN) : 8;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
    localparam bit                HAS_DROP = (DROP_EVERY > 0);
    localparam logic [7:0]        GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [16:0]       DROP_DIV = HAS_DROP ? 17'(DROP_EVERY) : 17'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    function automatic logic [7:0] ts_byte(
        input logic [IDX_W-1:0] idx,
        input logic [3:0]       cc,
        input logic [15:0]      seq,
        input logic [12:0]      pid
    );
        logic [7:0] b;
        case (idx)
            IDX_W'(0): b = 8'h47;
            IDX_W'(1): b = {3'b010, pid[12:8]};
            IDX_W'(2): b = pid[7:0];
            IDX_W'(3): b = {4'b0001, cc};
            default:   b = seq[7:0] + idx[7:0];
        endcase
        return b;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [12:0] PID = PID_BASE + 13'(gi);

            state_t           state_reg;
            logic [IDX_W-1:0] idx_reg;
            logic [3:0]       cc_reg;
            logic [15:0]      seq_reg;
            logic [15:0]      pkt_cnt_reg;
            logic [7:0]       gap_cnt_reg;
            logic             valid_reg;
            logic             sop_reg;
            logic             eop_reg;
            logic             loss_reg;
            logic [7:0]       byte_reg;

            logic             fire;
            logic             last;
            logic             skip;
            logic [IDX_W-1:0] idx_next;
            logic [16:0]      seq_plus1;
            logic [3:0]       cc_step;
            logic [7:0]       byte_next;

            assign fire      = valid_reg & ready[gi];
            assign last      = (idx_reg == LAST_IDX);
            assign idx_next  = idx_reg + IDX_W'(1);
            assign seq_plus1 = {1'b0, seq_reg} + 17'd1;
            // A skip is decided at the final transfer, from the packet count including this one.
            assign skip      = HAS_DROP && ((seq_plus1 % DROP_DIV) == 17'd0);
            assign cc_step   = cc_reg + (skip ? 4'd2 : 4'd1);
            assign byte_next = ts_byte(idx_next, cc_reg, seq_reg, PID);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg   <= ST_IDLE;
                    idx_reg     <= '0;
                    cc_reg      <= '0;
                    seq_reg     <= '0;
                    pkt_cnt_reg <= '0;
                    gap_cnt_reg <= '0;
                    valid_reg   <= 1'b0;
                    sop_reg     <= 1'b0;
                    eop_reg     <= 1'b0;
                    loss_reg    <= 1'b0;
                    byte_reg    <= '0;
                end else begin
                    loss_reg <= 1'b0;
                    case (state_reg)
                        ST_IDLE: begin
                            if (enable[gi]) begin
                                state_reg <= ST_SEND;
                                idx_reg   <= '0;
                                valid_reg <= 1'b1;
                                sop_reg   <= 1'b1;
                                eop_reg   <= 1'b0;
                                byte_reg  <= 8'h47;
                            end
                        end
                        ST_SEND: begin
                            if (fire) begin
                                if (last) begin
                                    pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                                    seq_reg     <= seq_reg + 16'd1;
                                    cc_reg      <= cc_step;
                                    loss_reg    <= skip;
                                    idx_reg     <= '0;
                                    if (HAS_GAP) begin
                                        state_reg   <= ST_GAP;
                                        gap_cnt_reg <= GAP_LOAD;
                                        valid_reg   <= 1'b0;
                                        sop_reg     <= 1'b0;
                                        eop_reg     <= 1'b0;
                                        byte_reg    <= '0;
                                    end else if (enable[gi]) begin
                                        // Back-to-back: next sync byte goes out with no bubble.
                                        valid_reg <= 1'b1;
                                        sop_reg   <= 1'b1;
                                        eop_reg   <= 1'b0;
                                        byte_reg  <= 8'h47;
                                    end else begin
                                        state_reg <= ST_IDLE;
                                        valid_reg <= 1'b0;
                                        sop_reg   <= 1'b0;
                                        eop_reg   <= 1'b0;
                                        byte_reg  <= '0;
                                    end
                                end else begin
                                    idx_reg  <= idx_next;
                                    byte_reg <= byte_next;
                                    sop_reg  <= 1'b0;
                                    eop_reg  <= (idx_next == LAST_IDX);
                                end
                            end
                        end
                        ST_GAP: begin
                            if (gap_cnt_reg == 8'd0) begin
                                if (enable[gi]) begin
                                    state_reg <= ST_SEND;
                                    idx_reg   <= '0;
                                    valid_reg <= 1'b1;
                                    sop_reg   <= 1'b1;
                                    eop_reg   <= 1'b0;
                                    byte_reg  <= 8'h47;
                                end else begin
                                    state_reg <= ST_IDLE;
                                end
                            end else begin
                                gap_cnt_reg <= gap_cnt_reg - 8'd1;
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end

            assign valid[gi]              = valid_reg;
            assign byte_data[gi*8 +: 8]   = byte_reg;
            assign sop[gi]                = sop_reg;
            assign eop[gi]                = eop_reg;
            assign loss_pulse[gi]         = loss_reg;
            assign pkt_cnt[gi*16 +: 16]   = pkt_cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ts_packet_source.sv
// Bench for ts_packet_source: three instances (4-channel base, loss injection, gaps)
// compared against an arithmetic model of the expected byte stream per channel.
module tb_ts_packet_source;

    localparam int PKT = 188;

    logic clk;
    logic rst_n;

    logic [3:0]  en_b, rdy_b, val_b, sop_b, eop_b, los_b;
    logic [31:0] dat_b;
    logic [63:0] cnt_b;

    logic [0:0]  en_d, rdy_d, val_d, sop_d, eop_d, los_d;
    logic [7:0]  dat_d;
    logic [15:0] cnt_d;

    logic [0:0]  en_g, rdy_g, val_g, sop_g, eop_g, los_g;
    logic [7:0]  dat_g;
    logic [15:0] cnt_g;

    int vectors;
    int miscompares;
    bit rmode;

    // Model state, indexed [instance][channel]
    int nb        [3][4];
    bit after_eop [3][4];
    int idle      [3][4];
    bit exp_loss  [3][4];
    bit chk_gap   [3][4];
    int loss_seen [3][4];

    ts_packet_source #(.NUM_CH(4)) u_base (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .ready(rdy_b), .valid(val_b),
        .byte_data(dat_b), .sop(sop_b), .eop(eop_b), .loss_pulse(los_b), .pkt_cnt(cnt_b)
    );

    ts_packet_source #(.NUM_CH(1), .DROP_EVERY(3)) u_drop (
        .clk(clk), .rst_n(rst_n), .enable(en_d), .ready(rdy_d), .valid(val_d),
        .byte_data(dat_d), .sop(sop_d), .eop(eop_d), .loss_pulse(los_d), .pkt_cnt(cnt_d)
    );

    ts_packet_source #(.NUM_CH(1), .GAP_CYCLES(5)) u_gap (
        .clk(clk), .rst_n(rst_n), .enable(en_g), .ready(rdy_g), .valid(val_g),
        .byte_data(dat_g), .sop(sop_g), .eop(eop_g), .loss_pulse(los_g), .pkt_cnt(cnt_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int drop_of(input int inst);
        return (inst == 1) ? 3 : 0;
    endfunction

    function automatic int gap_of(input int inst);
        return (inst == 2) ? 5 : 0;
    endfunction

    // n-th accepted byte of a channel, straight from the packet layout rules.
    function automatic logic [7:0] exp_byte(input int inst, input int ch, input int n);
        int p, i, cc, pid, d;
        p   = n / PKT;
        i   = n % PKT;
        d   = drop_of(inst);
        cc  = (p + ((d > 0) ? p / d : 0)) % 16;
        pid = 'h100 + ch;
        case (i)
            0:       return 8'h47;
            1:       return 8'(32'h40 | (pid >> 8));
            2:       return 8'(pid);
            3:       return 8'(32'h10 | cc);
            default: return 8'(p + i);
        endcase
    endfunction

    task automatic chk(input string tag, input int inst, input int ch,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s inst%0d ch%0d: observed %0h expected %0h", tag, inst, ch, obs, exp_v);
        end
    endtask

    task automatic mon(input int inst, input int ch, input logic v, input logic r,
                       input logic [7:0] d, input logic s, input logic e, input logic l,
                       input logic [15:0] pc);
        int i, p, dr;
        i  = nb[inst][ch] % PKT;
        dr = drop_of(inst);
        chk("loss_pulse", inst, ch, 32'(l), 32'(exp_loss[inst][ch]));
        exp_loss[inst][ch] = 1'b0;
        if (l) loss_seen[inst][ch]++;
        chk("pkt_cnt", inst, ch, 32'(pc), 32'((nb[inst][ch] / PKT) % 65536));
        chk("valid_hold", inst, ch, 32'(v | (i == 0)), 32'd1);
        if (v) begin
            chk("byte", inst, ch, 32'(d), 32'(exp_byte(inst, ch, nb[inst][ch])));
            chk("sop", inst, ch, 32'(s), 32'(i == 0));
            chk("eop", inst, ch, 32'(e), 32'(i == PKT - 1));
            if (after_eop[inst][ch] && i == 0) begin
                if (chk_gap[inst][ch]) chk("gap", inst, ch, 32'(idle[inst][ch]), 32'(gap_of(inst)));
                after_eop[inst][ch] = 1'b0;
            end
            if (r) begin
                if (i == PKT - 1) begin
                    after_eop[inst][ch] = 1'b1;
                    idle[inst][ch]      = 0;
                    p = nb[inst][ch] / PKT;
                    if (dr > 0 && ((p + 1) % dr) == 0) exp_loss[inst][ch] = 1'b1;
                end
                nb[inst][ch]++;
            end
        end else if (after_eop[inst][ch]) begin
            idle[inst][ch]++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 3; a++) begin
                for (int c = 0; c < 4; c++) begin
                    nb[a][c]        = 0;
                    after_eop[a][c] = 1'b0;
                    idle[a][c]      = 0;
                    exp_loss[a][c]  = 1'b0;
                    loss_seen[a][c] = 0;
                end
            end
        end else begin
            for (int c = 0; c < 4; c++)
                mon(0, c, val_b[c], rdy_b[c], dat_b[c*8 +: 8], sop_b[c], eop_b[c], los_b[c], cnt_b[c*16 +: 16]);
            mon(1, 0, val_d[0], rdy_d[0], dat_d, sop_d[0], eop_d[0], los_d[0], cnt_d);
            mon(2, 0, val_g[0], rdy_g[0], dat_g, sop_g[0], eop_g[0], los_g[0], cnt_g);
        end
    end

    // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) begin
            rdy_b = 4'($urandom_range(0, 15));
            rdy_d = 1'($urandom_range(0, 1));
            rdy_g = 1'($urandom_range(0, 1));
        end else begin
            rdy_b = 4'hF;
            rdy_d = 1'b1;
            rdy_g = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 0, 0, 32'(val_b), 32'd0);
        chk({tag, "_sop"},   0, 0, 32'(sop_b), 32'd0);
        chk({tag, "_eop"},   0, 0, 32'(eop_b), 32'd0);
        chk({tag, "_loss"},  0, 0, 32'(los_b), 32'd0);
        chk({tag, "_data"},  0, 0, dat_b, 32'd0);
        chk({tag, "_cnt_lo"}, 0, 0, cnt_b[31:0], 32'd0);
        chk({tag, "_cnt_hi"}, 0, 0, cnt_b[63:32], 32'd0);
        chk({tag, "_valid"}, 1, 0, 32'({val_d, val_g}), 32'd0);
        chk({tag, "_data"},  1, 0, 32'({dat_d, dat_g}), 32'd0);
        chk({tag, "_cnt"},   1, 0, {cnt_d, cnt_g}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  found;
        vectors     = 0;
        miscompares = 0;
        rmode       = 1'b0;
        rst_n       = 1'b0;
        en_b = '0; en_d = '0; en_g = '0;
        rdy_b = '1; rdy_d = '1; rdy_g = '1;
        for (int a = 0; a < 3; a++)
            for (int c = 0; c < 4; c++) chk_gap[a][c] = 1'b1;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_enable", 0, 0, 32'(val_b), 32'd0);

        // Enable: first valid cycle carries the sync byte with sop
        en_b = 4'hF; en_d = 1'b1; en_g = 1'b1;
        tick();
        chk("first_valid", 0, 0, 32'(val_b), 32'hF);
        chk("first_sop", 0, 0, 32'(sop_b), 32'hF);
        chk("first_byte", 0, 0, dat_b, 32'h47474747);

        // Full-rate streaming
        repeat (420) tick();
        chk("two_pkts_fullrate", 0, 0, 32'(cnt_b[15:0] >= 16'd2), 32'd1);

        // Random backpressure
        rmode = 1'b1;
        repeat (1500) tick();
        chk("drop_inst_exercised", 1, 0, 32'(nb[1][0] / PKT >= 3), 32'd1);
        chk("loss_count", 1, 0, 32'(loss_seen[1][0]),
            32'((nb[1][0] / PKT) / 3 - int'(exp_loss[1][0])));

        // Enable drop at idx 50 on base channel 0
        chk_gap[0][0] = 1'b0;
        found = 1'b0;
        for (n = 0; n < 3000 && !found; n++) begin
            if (nb[0][0] % PKT == 50) found = 1'b1;
            else tick();
        end
        chk("wait_idx50", 0, 0, 32'(found), 32'd1);
        en_b[0] = 1'b0;
        tick();
        found = 1'b0;
        for (n = 0; n < 3000 && !found; n++) begin
            if (nb[0][0] % PKT == 0) found = 1'b1;
            else tick();
        end
        chk("wait_pkt_end", 0, 0, 32'(found), 32'd1);
        for (int k = 0; k < 20; k++) begin
            chk("stopped_valid", 0, 0, 32'(val_b[0]), 32'd0);
            tick();
        end
        en_b[0] = 1'b1;
        tick();
        chk("resume_valid", 0, 0, 32'(val_b[0]), 32'd1);
        chk("resume_byte", 0, 0, 32'(dat_b[7:0]), 32'h47);
        repeat (800) tick();

        // Asynchronous reset at idx 100 of base channel 0
        found = 1'b0;
        for (n = 0; n < 3000 && !found; n++) begin
            if (nb[0][0] % PKT == 100) found = 1'b1;
            else tick();
        end
        chk("wait_idx100", 0, 0, 32'(found), 32'd1);
        chk("pre_reset_valid", 0, 0, 32'(val_b[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        chk_gap[0][0] = 1'b1;
        tick();
        chk("post_reset_valid", 0, 0, 32'(val_b[0]), 32'd1);
        chk("post_reset_byte", 0, 0, 32'(dat_b[7:0]), 32'h47);
        chk("post_reset_cnt", 0, 0, 32'(cnt_b[15:0]), 32'd0);
        repeat (600) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
